// File: rtl/alu_cmd_issue_if.sv
// Command and result channels between the ALU issue front-end and its neighbours.
// Optional macro ALU_ISSUE_ACC_EN adds the cmd_acc field to the command channel.
interface alu_cmd_issue_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic [3:0] cmd_sel;
`ifdef ALU_ISSUE_ACC_EN
  logic       cmd_acc;
`endif
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_carry;
  logic       res_zero;
  logic       res_err;

`ifdef ALU_ISSUE_ACC_EN
  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_acc, res_ready,
    input  cmd_ready, res_valid, res_data, res_carry, res_zero, res_err
  );
  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_acc, res_ready,
    output cmd_ready, res_valid, res_data, res_carry, res_zero, res_err
  );
`else
  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_sel, res_ready,
    input  cmd_ready, res_valid, res_data, res_carry, res_zero, res_err
  );
  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_sel, res_ready,
    output cmd_ready, res_valid, res_data, res_carry, res_zero, res_err
  );
`endif
endinterface

// File: rtl/alu_cmd_issue.sv
// Command FIFO + issue FSM in front of an 8-bit combinational ALU; captures result and flags.
// Optional macro ALU_ISSUE_ACC_EN adds per-command accumulator chaining of the B operand.
module alu_cmd_issue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_cmd_issue_if.slave bus,
  output logic [7:0]    alu_a,
  output logic [7:0]    alu_b,
  output logic [3:0]    alu_sel,
  input  logic [7:0]    alu_out,
  input  logic          alu_carry,
  output logic [AW:0]   fifo_level
);

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] sel;
`ifdef ALU_ISSUE_ACC_EN
    logic       acc;
`endif
  } entry_t;

  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  function automatic logic div_zero(input logic [3:0] sel, input logic [7:0] b);
    return (sel == 4'b0011) && (b == 8'h00);
  endfunction

  function automatic logic [7:0] cap_data(input logic [7:0] out, input logic dz);
    return dz ? 8'hFF : out;
  endfunction

  state_t        state, state_nxt;
  entry_t        mem [DEPTH];
  entry_t        wr_entry, head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, empty, push, pop;
  logic [7:0]    op_b;
  logic          dz;
  logic [7:0]    cap_d;

  assign full          = (fifo_level == LVL_FULL);
  assign empty         = (fifo_level == '0);
  assign bus.cmd_ready = !full;
  assign push          = bus.cmd_valid && !full;
  assign pop           = !empty && ((state == IDLE) || ((state == HOLD) && bus.res_ready));
  assign head          = mem[rd_ptr];

  always_comb begin
    wr_entry.a   = bus.cmd_a;
    wr_entry.b   = bus.cmd_b;
    wr_entry.sel = bus.cmd_sel;
`ifdef ALU_ISSUE_ACC_EN
    wr_entry.acc = bus.cmd_acc;
`endif
  end

  // Command FIFO: storage holds data only, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + (AW+1)'(1);
        2'b01:   fifo_level <= fifo_level - (AW+1)'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty) state_nxt = EXEC;
      EXEC:    state_nxt = HOLD;
      HOLD:    if (bus.res_ready) state_nxt = empty ? IDLE : EXEC;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef ALU_ISSUE_ACC_EN
  logic [7:0] acc_q;
  // The previous command is always captured before the next pop, so acc_q is already current.
  assign op_b = head.acc ? acc_q : head.b;
`else
  assign op_b = head.b;
`endif

  // Issue stage: operands registered toward the ALU, held between commands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= '0;
    end else if (pop) begin
      alu_a   <= head.a;
      alu_b   <= op_b;
      alu_sel <= head.sel;
    end
  end

  assign dz    = div_zero(alu_sel, alu_b);
  assign cap_d = cap_data(alu_out, dz);

  // Capture stage: ALU output registered one cycle after issue, held until handed off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_carry <= 1'b0;
      bus.res_zero  <= 1'b0;
      bus.res_err   <= 1'b0;
    end else if (state == EXEC) begin
      bus.res_valid <= 1'b1;
      bus.res_data  <= cap_d;
      bus.res_carry <= alu_carry & (alu_sel == 4'b0000);
      bus.res_zero  <= (cap_d == 8'h00);
      bus.res_err   <= dz;
    end else if ((state == HOLD) && bus.res_ready) begin
      bus.res_valid <= 1'b0;
    end
  end

`ifdef ALU_ISSUE_ACC_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              acc_q <= '0;
    else if (state == EXEC)  acc_q <= cap_d;
  end
`endif

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Scoreboard bench for alu_cmd_issue with a behavioural model of the downstream 8-bit ALU.
module tb_alu_cmd_issue;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
`ifdef ALU_ISSUE_ACC_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       carry;
    logic       zero;
    logic       err;
  } res_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    alu_a, alu_b, alu_out;
  logic [3:0]    alu_sel;
  logic          alu_carry;
  logic [AW:0]   fifo_level;

  res_t       exp_q[$];
  res_t       obs_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] model_acc = 8'h00;

  alu_cmd_issue_if bus();

  alu_cmd_issue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_out    (alu_out),
    .alu_carry  (alu_carry),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] s);
    logic [8:0] sum;
    logic [7:0] r;
    sum = {1'b0, a} + {1'b0, b};
    case (s)
      4'h0: r = sum[7:0];
      4'h1: r = a - b;
      4'h2: r = 8'(a * b);
      4'h3: r = (b == 8'h00) ? 8'h00 : a / b;
      4'h4: r = a << 1;
      4'h5: r = a >> 1;
      4'h6: r = {a[6:0], a[7]};
      4'h7: r = {a[0], a[7:1]};
      4'h8: r = a & b;
      4'h9: r = a | b;
      4'hA: r = a ^ b;
      4'hB: r = ~(a | b);
      4'hC: r = ~(a & b);
      4'hD: r = ~(a ^ b);
      4'hE: r = (a > b) ? 8'h01 : 8'h00;
      default: r = (a == b) ? 8'h01 : 8'h00;
    endcase
    return {sum[8], r};
  endfunction

  always_comb {alu_carry, alu_out} = alu_model(alu_a, alu_b, alu_sel);

  // Records each result in the cycle before the edge that hands it off.
  always @(negedge clk) begin
    if (rst_n && bus.res_valid && bus.res_ready)
      obs_q.push_back({bus.res_data, bus.res_carry, bus.res_zero, bus.res_err});
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s,
                      input logic acc, output bit ok);
    logic [7:0] eb;
    logic [8:0] r;
    res_t       e;
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_sel   = s;
`ifdef ALU_ISSUE_ACC_EN
    bus.cmd_acc   = acc;
`endif
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      ok = bus.cmd_ready;
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
    if (ok) begin
      eb      = (acc && ACC_EN) ? model_acc : b;
      r       = alu_model(a, eb, s);
      e.err   = (s == 4'h3) && (eb == 8'h00);
      e.data  = e.err ? 8'hFF : r[7:0];
      e.carry = r[8] & (s == 4'h0);
      e.zero  = (e.data == 8'h00);
      exp_q.push_back(e);
      model_acc = e.data;
    end else begin
      n_tests++; n_fail++;
      $display("FAIL send_accept: command a=%h b=%h sel=%h never accepted", a, b, s);
    end
  endtask

  task automatic wait_obs(input int n);
    for (int i = 0; i < 100 && obs_q.size() < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({bus.res_valid, bus.res_data, bus.res_carry, bus.res_zero, bus.res_err} !== 12'h000) begin
      n_fail++; $display("FAIL reset_res: got %h required 000",
        {bus.res_valid, bus.res_data, bus.res_carry, bus.res_zero, bus.res_err});
    end
    n_tests++;
    if ({alu_a, alu_b, alu_sel, fifo_level} !== 23'h0) begin
      n_fail++; $display("FAIL reset_regs: got %h required 0", {alu_a, alu_b, alu_sel, fifo_level});
    end
    n_tests++;
    if (bus.cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b required 1", bus.cmd_ready);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add_carry();
    bit   ok;
    res_t o, e;
    bus.res_ready = 1'b0;
    send(8'hF6, 8'h0A, 4'h0, 1'b0, ok);
    n_tests++;
    if (bus.res_valid !== 1'b0) begin
      n_fail++; $display("FAIL lat_e0_valid: got %b required 0", bus.res_valid);
    end
    @(posedge clk); #1;
    n_tests++;
    if ({bus.res_valid, alu_a, alu_b, alu_sel} !== {1'b0, 8'hF6, 8'h0A, 4'h0}) begin
      n_fail++; $display("FAIL lat_e1_issue: got %h required %h",
        {bus.res_valid, alu_a, alu_b, alu_sel}, {1'b0, 8'hF6, 8'h0A, 4'h0});
    end
    @(posedge clk); #1;
    n_tests++;
    if ({bus.res_valid, bus.res_data, bus.res_carry, bus.res_zero, bus.res_err} !==
        {1'b1, 8'h00, 1'b1, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL add_carry: got %h required %h",
        {bus.res_valid, bus.res_data, bus.res_carry, bus.res_zero, bus.res_err},
        {1'b1, 8'h00, 1'b1, 1'b1, 1'b0});
    end
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({bus.res_valid, bus.res_data, bus.res_carry} !== {1'b1, 8'h00, 1'b1}) begin
      n_fail++; $display("FAIL hold_stable: got %h required %h",
        {bus.res_valid, bus.res_data, bus.res_carry}, {1'b1, 8'h00, 1'b1});
    end
    bus.res_ready = 1'b1;
    wait_obs(1);
    if (obs_q.size() > 0 && exp_q.size() > 0) begin o = obs_q.pop_front(); e = exp_q.pop_front(); end
    else begin o = 'x; e = '0; end
    n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL add_handoff: got %h required %h", o, e); end
  endtask

  task automatic test_sub_mul();
    bit         ok;
    res_t       o, e;
    logic [7:0] lit [2];
    lit[0] = 8'h08; lit[1] = 8'h14;
    bus.res_ready = 1'b1;
    send(8'h0A, 8'h02, 4'h1, 1'b0, ok);
    send(8'h0A, 8'h02, 4'h2, 1'b0, ok);
    wait_obs(2);
    for (int i = 0; i < 2; i++) begin
      if (obs_q.size() > 0 && exp_q.size() > 0) begin o = obs_q.pop_front(); e = exp_q.pop_front(); end
      else begin o = 'x; e = '0; end
      n_tests++;
      if (o !== e || o.data !== lit[i] || o.carry !== 1'b0) begin
        n_fail++; $display("FAIL sub_mul[%0d]: got %h required %h (data %h)", i, o, e, lit[i]);
      end
    end
  endtask

  task automatic test_div();
    bit   ok;
    res_t o;
    res_t lit [2];
    lit[0] = {8'hFF, 1'b0, 1'b0, 1'b1};
    lit[1] = {8'h05, 1'b0, 1'b0, 1'b0};
    bus.res_ready = 1'b1;
    send(8'h0A, 8'h00, 4'h3, 1'b0, ok);
    send(8'h0A, 8'h02, 4'h3, 1'b0, ok);
    wait_obs(2);
    for (int i = 0; i < 2; i++) begin
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      n_tests++;
      if (o !== lit[i]) begin n_fail++; $display("FAIL div[%0d]: got %h required %h", i, o, lit[i]); end
    end
  endtask

  task automatic test_full();
    bit   ok;
    res_t o, e;
    bus.res_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      send(8'(8'h11 * i + 1), 8'(i + 1), 4'(i), 1'b0, ok);
    bus.cmd_valid = 1'b1;
    bus.cmd_a = 8'h99; bus.cmd_b = 8'h01; bus.cmd_sel = 4'h8;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({bus.cmd_ready, fifo_level} !== {1'b0, 3'd4}) begin
      n_fail++; $display("FAIL full_block: got ready/level %h required %h", {bus.cmd_ready, fifo_level}, {1'b0, 3'd4});
    end
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if ({bus.cmd_ready, fifo_level} !== {1'b1, 3'd3}) begin
      n_fail++; $display("FAIL full_release: got ready/level %h required %h", {bus.cmd_ready, fifo_level}, {1'b1, 3'd3});
    end
    wait_obs(5);
    n_tests++;
    if (obs_q.size() !== 5) begin n_fail++; $display("FAIL full_count: got %0d required 5", obs_q.size()); end
    for (int i = 0; i < 5; i++) begin
      if (obs_q.size() > 0 && exp_q.size() > 0) begin o = obs_q.pop_front(); e = exp_q.pop_front(); end
      else begin o = 'x; e = '0; end
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL full_order[%0d]: got %h required %h", i, o, e); end
    end
  endtask

  task automatic test_back_to_back();
    bit   ok;
    res_t o, e;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 12; i++)
      send(8'($urandom), (i % 4 == 0) ? 8'h00 : 8'($urandom), 4'($urandom), 1'b0, ok);
    wait_obs(12);
    for (int i = 0; i < 12; i++) begin
      if (obs_q.size() > 0 && exp_q.size() > 0) begin o = obs_q.pop_front(); e = exp_q.pop_front(); end
      else begin o = 'x; e = '0; end
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL b2b[%0d]: got %h required %h", i, o, e); end
    end
  endtask

  task automatic test_reset_mid();
    bit   ok;
    res_t o, e;
    bus.res_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send(8'(8'h20 + i), 8'h03, 4'h9, 1'b0, ok);
    bus.res_ready = 1'b1;
    send(8'h24, 8'h03, 4'h9, 1'b0, ok);
    n_tests++;
    if ({fifo_level, bus.res_valid, alu_a} !== {3'd3, 1'b0, 8'h21}) begin
      n_fail++; $display("FAIL midrst_setup: got %h required %h", {fifo_level, bus.res_valid, alu_a}, {3'd3, 1'b0, 8'h21});
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.res_valid, bus.res_data, bus.res_carry, bus.res_zero, bus.res_err,
         alu_a, alu_b, alu_sel, fifo_level, bus.cmd_ready} !== 36'h1) begin
      n_fail++; $display("FAIL midrst_clear: got %h required 1",
        {bus.res_valid, bus.res_data, bus.res_carry, bus.res_zero, bus.res_err,
         alu_a, alu_b, alu_sel, fifo_level, bus.cmd_ready});
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    n_tests++;
    if (obs_q.size() !== 1) begin n_fail++; $display("FAIL midrst_count: got %0d required 1", obs_q.size()); end
    if (obs_q.size() > 0 && exp_q.size() > 0) begin o = obs_q.pop_front(); e = exp_q.pop_front(); end
    else begin o = 'x; e = '0; end
    n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL midrst_first: got %h required %h", o, e); end
    obs_q.delete();
    exp_q.delete();
    model_acc = 8'h00;
  endtask

`ifdef ALU_ISSUE_ACC_EN
  task automatic test_acc();
    bit         ok;
    res_t       o, e;
    logic [7:0] lit [3];
    lit[0] = 8'h08; lit[1] = 8'h18; lit[2] = 8'hE7;
    bus.res_ready = 1'b1;
    send(8'h05, 8'h03, 4'h0, 1'b0, ok);
    send(8'h10, 8'h77, 4'h0, 1'b1, ok);
    send(8'hFF, 8'h77, 4'hA, 1'b1, ok);
    wait_obs(3);
    for (int i = 0; i < 3; i++) begin
      if (obs_q.size() > 0 && exp_q.size() > 0) begin o = obs_q.pop_front(); e = exp_q.pop_front(); end
      else begin o = 'x; e = '0; end
      n_tests++;
      if (o !== e || o.data !== lit[i]) begin
        n_fail++; $display("FAIL acc[%0d]: got %h required %h (data %h)", i, o, e, lit[i]);
      end
    end
  endtask
`endif

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_sel   = '0;
`ifdef ALU_ISSUE_ACC_EN
    bus.cmd_acc   = 1'b0;
`endif
    bus.res_ready = 1'b0;
    test_reset();
    test_add_carry();
    test_sub_mul();
    test_div();
    test_full();
    test_back_to_back();
    test_reset_mid();
`ifdef ALU_ISSUE_ACC_EN
    test_acc();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
